turbo_rx_checker: RTL
=====================

Name: turbo_rx_checker

Overview:
- Receive-side counterpart of the byte-parallel turbo encoder top.
- Consumes the encoder's xk / zk / zk' byte streams plus the valid strobe, and strips the tail beat.
- Forwards systematic bytes downstream.
- Re-encodes xk through a local constituent RSC (g0 = 1+D^2+D^3, g1 = 1+D+D^3), compares against received zk, and reports a per-block parity-error count and a trellis-termination check.
- Used as a loopback/BIST checker ahead of the decoder.

Parameters:
- CNT_W, 14, width of err_count (holds at most 6144+3 mismatches).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  synchronous pulse: begin new block, sample block_size
- block_size  input  1  0 = 1056 bits (132 data beats), 1 = 6144 bits (768 data beats)
- in_valid  input  1  xk_in/zk_in/zkp_in carry a beat this cycle
- xk_in  input  8  systematic byte, bit 7 earliest in time
- zk_in  input  8  parity byte of encoder 1
- zkp_in  input  8  parity byte of encoder 2 (forwarded only)
- sys_out  output  8  registered systematic byte
- zp_out  output  8  registered zk' byte
- sys_valid  output  1  sys_out/zp_out valid (no backpressure)
- sys_last  output  1  high with last data beat of block
- done  output  1  one-cycle pulse: block results valid
- err_count  output  CNT_W  parity mismatches in data plus tail z bits; held until next start
- tail_ok  output  1  received tail equals locally generated termination; held
- framing_err  output  1  sticky: beat received while not expecting one; cleared by start
- busy  output  1  high in DATA or TAIL

Behaviour:
- Reset values: all outputs 0; state IDLE; RSC state s0..s2 = 0; beat counter 0.
- States:
  - IDLE: wait for start.
  - DATA: accept beats until 132/768 counted.
  - TAIL: accept one tail beat.
  - DONE: single cycle, asserts done, returns to IDLE.
- Start handling:
  - start in any state (including mid-DATA/TAIL) clears counters, RSC state, err_count, tail_ok and framing_err, latches block_size, and enters DATA next cycle.
  - start has priority over a simultaneous in_valid beat; that beat is discarded.
- Data beat, per bit, MSB first, with state (s0,s1,s2) = D1..D3:
  - fb = x ^ s1 ^ s2
  - zexp = fb ^ s0 ^ s2
  - new state = (fb, s0, s1)
  - Eight bits are chained combinationally per beat.
  - err_count += popcount(zexp ^ zk_in), saturating at all-ones.
- Data beat outputs:
  - sys_out = xk_in and zp_out = zkp_in, registered one cycle after acceptance.
  - sys_valid is high for exactly one cycle per accepted data beat.
  - sys_last accompanies beat 132/768.
- in_valid low cycles (gaps) hold all state; any gap length is allowed.
- Tail beat layout:
  - xk_in[7:5] = x_K..x_K+2
  - zk_in[7:5] = z_K..z_K+2
  - zkp_in[7:5] and zk_in/xk_in[4:0] are ignored; tail is not forwarded (sys_valid stays low).
- Tail expectation, 3 steps from final state:
  - xexp = s1 ^ s2
  - zexp = s0 ^ s2
  - shift in 0
- Tail result:
  - tail_ok = all three xexp match.
  - z mismatches in the tail add to err_count.
- done asserts the cycle after the tail beat is accepted; err_count and tail_ok are stable in that same cycle.
- in_valid in IDLE or DONE sets framing_err; the beat is ignored and counters are unchanged.
- Asynchronous reset mid-block returns to IDLE immediately; no done is issued.

Optional Feature:
- Macro TURBO_RX_STATS_EN.
- When defined, adds outputs blk_count[15:0] and bad_blk_count[15:0]:
  - Both increment at done, wrapping at 16 bits.
  - bad_blk_count increments when err_count != 0 or tail_ok == 0.
  - Both are cleared only by reset, not by start.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- All-zero block, block_size=0, start then 132 beats of x=z=z'=0x00, then tail 0x00/0x00 -> 132 sys_valid pulses of 0x00, sys_last on the 132nd, done one cycle after the tail, err_count=0, tail_ok=1.
- First beat xk=0x80, zk=0xF2, followed by model-generated bytes, block_size=1 (768 beats) -> err_count=0, tail_ok=1. Repeating the run with the first zk=0xF3 -> err_count=1.
- Valid block with tail xk[7:5] bit 6 flipped -> tail_ok=0, err_count=0. With a tail zk bit flipped instead -> tail_ok=1, err_count=1.
- Same 1056-bit block with in_valid randomly deasserted (gaps of 1-5 cycles) -> identical sys_out sequence, err_count and tail_ok as the gapless run.
- start reasserted after 50 data beats, then a full clean block -> no done for the aborted block; one done with err_count=0. In a separate run, an in_valid beat after done -> framing_err=1 until the next start.
- With TURBO_RX_STATS_EN: 3 blocks, second with one parity error -> blk_count=3, bad_blk_count=1; asynchronous reset mid-third-block -> all outputs 0.

Source files
------------

// File: rtl/turbo_rx_checker.sv
// -----------------------------------------------------------------------------
// turbo_rx_checker
//
// Receive-side loopback/BIST checker for the byte-parallel turbo encoder.
// It takes the encoder's xk / zk / zk' byte streams and forwards the systematic
// and second-parity bytes downstream. The tail beat is stripped off. The xk
// stream is re-encoded through a local RSC constituent encoder
// (g0 = 1+D^2+D^3 feedback, g1 = 1+D+D^3 feed-forward). The regenerated parity
// is compared against the received zk stream. Per block it reports the number
// of parity-bit mismatches and whether the received trellis termination
// matches the one generated locally.
//
// Optional build: define TURBO_RX_STATS_EN to add the blk_count and
// bad_blk_count block statistics outputs.
//
// Ports
//   clock        in   system clock
//   reset        in   asynchronous, active-high, clears all state
//   start        in   pulse: begin a new block, samples block_size
//   block_size   in   0 = 1056 bits (132 data beats), 1 = 6144 bits (768 beats)
//   in_valid     in   xk_in/zk_in/zkp_in carry a beat this cycle
//   xk_in[7:0]   in   systematic byte, bit 7 earliest in time
//   zk_in[7:0]   in   parity byte of encoder 1 (checked)
//   zkp_in[7:0]  in   parity byte of encoder 2 (forwarded only)
//   sys_out      out  registered systematic byte
//   zp_out       out  registered zk' byte
//   sys_valid    out  sys_out/zp_out valid, one cycle per data beat
//   sys_last     out  high with the last data beat of the block
//   done         out  one-cycle pulse, block results valid
//   err_count    out  parity mismatches over data plus tail z bits, saturating
//   tail_ok      out  received tail x bits equal the local termination
//   framing_err  out  sticky, a beat arrived while none was expected
//   busy         out  high while in DATA or TAIL
//   blk_count     out (TURBO_RX_STATS_EN) completed blocks, wraps
//   bad_blk_count out (TURBO_RX_STATS_EN) completed blocks with any error
// -----------------------------------------------------------------------------
module turbo_rx_checker #(
  parameter int CNT_W = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             block_size,
  input  logic             in_valid,
  input  logic [7:0]       xk_in,
  input  logic [7:0]       zk_in,
  input  logic [7:0]       zkp_in,
  output logic [7:0]       sys_out,
  output logic [7:0]       zp_out,
  output logic             sys_valid,
  output logic             sys_last,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic             tail_ok,
  output logic             framing_err,
  output logic             busy
`ifdef TURBO_RX_STATS_EN
  ,
  output logic [15:0]      blk_count,
  output logic [15:0]      bad_blk_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     r_state;
  logic [2:0] r_rscState;   // [0] = s0 (D1), [1] = s1 (D2), [2] = s2 (D3)
  logic [9:0] r_beatCnt;
  logic       r_blockSize;

  logic [2:0]       w_dataState;
  logic [7:0]       w_dataZexp;
  logic [7:0]       w_dataMis;
  logic [3:0]       w_dataPop;
  logic [2:0]       w_tailState;
  logic [2:0]       w_tailXexp;
  logic [2:0]       w_tailZexp;
  logic [2:0]       w_tailZMis;
  logic [3:0]       w_tailPop;
  logic             w_tailMatch;
  logic [3:0]       w_addPop;
  logic [CNT_W:0]   w_errSum;
  logic [CNT_W-1:0] w_errNext;
  logic [9:0]       w_lastIdx;

  // Re-encode the eight bits of a data beat, MSB first, chaining the RSC
  // state through all eight steps within one cycle.
  always_comb begin
    w_dataState = r_rscState;
    w_dataZexp  = '0;
    for (int i = 7; i >= 0; i--) begin
      w_dataZexp[i] = (xk_in[i] ^ w_dataState[1] ^ w_dataState[2]) ^
                      w_dataState[0] ^ w_dataState[2];
      w_dataState   = {w_dataState[1], w_dataState[0],
                       xk_in[i] ^ w_dataState[1] ^ w_dataState[2]};
    end
    w_dataMis = w_dataZexp ^ zk_in;
    w_dataPop = '0;
    for (int i = 0; i < 8; i++) begin
      w_dataPop = w_dataPop + {3'b000, w_dataMis[i]};
    end
  end

  // Termination: the tail x bit is the one that drives the feedback to zero,
  // so each step simply shifts a zero into the register.
  always_comb begin
    w_tailState = r_rscState;
    w_tailXexp  = '0;
    w_tailZexp  = '0;
    for (int i = 2; i >= 0; i--) begin
      w_tailXexp[i] = w_tailState[1] ^ w_tailState[2];
      w_tailZexp[i] = w_tailState[0] ^ w_tailState[2];
      w_tailState   = {w_tailState[1], w_tailState[0], 1'b0};
    end
    w_tailZMis  = w_tailZexp ^ zk_in[7:5];
    w_tailMatch = (w_tailXexp == xk_in[7:5]);
    w_tailPop   = {3'b000, w_tailZMis[0]} + {3'b000, w_tailZMis[1]} +
                  {3'b000, w_tailZMis[2]};
  end

  // Saturating accumulate of whichever mismatch count applies this cycle.
  always_comb begin
    w_addPop  = (r_state == TAIL) ? w_tailPop : w_dataPop;
    w_errSum  = {1'b0, err_count} + {{(CNT_W-3){1'b0}}, w_addPop};
    w_errNext = w_errSum[CNT_W] ? {CNT_W{1'b1}} : w_errSum[CNT_W-1:0];
    w_lastIdx = r_blockSize ? 10'd767 : 10'd131;
  end

  // Block FSM with all outputs registered. start wins over everything,
  // including a beat presented in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rscState  <= '0;
      r_beatCnt   <= '0;
      r_blockSize <= 1'b0;
      sys_out     <= '0;
      zp_out      <= '0;
      sys_valid   <= 1'b0;
      sys_last    <= 1'b0;
      done        <= 1'b0;
      err_count   <= '0;
      tail_ok     <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
`ifdef TURBO_RX_STATS_EN
      blk_count     <= '0;
      bad_blk_count <= '0;
`endif
    end else begin
      sys_valid <= 1'b0;
      sys_last  <= 1'b0;
      done      <= 1'b0;
      if (start) begin
        r_state     <= DATA;
        r_rscState  <= '0;
        r_beatCnt   <= '0;
        r_blockSize <= block_size;
        err_count   <= '0;
        tail_ok     <= 1'b0;
        framing_err <= 1'b0;
        busy        <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (in_valid) framing_err <= 1'b1;
          end
          DATA: begin
            if (in_valid) begin
              r_rscState <= w_dataState;
              err_count  <= w_errNext;
              sys_out    <= xk_in;
              zp_out     <= zkp_in;
              sys_valid  <= 1'b1;
              if (r_beatCnt == w_lastIdx) begin
                sys_last  <= 1'b1;
                r_beatCnt <= '0;
                r_state   <= TAIL;
              end else begin
                r_beatCnt <= r_beatCnt + 10'd1;
              end
            end
          end
          TAIL: begin
            if (in_valid) begin
              r_rscState <= w_tailState;
              err_count  <= w_errNext;
              tail_ok    <= w_tailMatch;
              done       <= 1'b1;
              busy       <= 1'b0;
              r_state    <= DONE;
`ifdef TURBO_RX_STATS_EN
              blk_count <= blk_count + 16'd1;
              if ((w_errNext != '0) || !w_tailMatch) begin
                bad_blk_count <= bad_blk_count + 16'd1;
              end
`endif
            end
          end
          DONE: begin
            r_state <= IDLE;
            if (in_valid) framing_err <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
